vga_frame_reader: RTL
=====================

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter H_PIXELS, default 1920, visible columns per row.
REQ-002 SHALL have parameter V_PIXELS, default 1200, visible rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 22, frame-memory pixel address width (2^ADDR_W >= H_PIXELS*V_PIXELS).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 4, prefetch buffer entries.
REQ-005 pixel_clk  in  1  pixel clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 disp_ena  in  1  display enable from the timing generator.
REQ-008 column, row  in  12 each  pixel coordinates from the timing generator.
REQ-009 h_sync_in, v_sync_in  in  1 each  syncs from the timing generator.
REQ-010 rd_req_valid  out  1; rd_req_ready  in  1; rd_addr  out  ADDR_W: memory read-request handshake.
REQ-011 rd_data_valid  in  1; rd_data  in  24: read data in request order, {R[23:16],G[15:8],B[7:0]}, no backpressure.
REQ-012 red, green, blue  out  8 each  registered pixel colour.
REQ-013 h_sync_out, v_sync_out, disp_ena_out  out  1 each  inputs delayed one cycle.
REQ-014 underflow  out  1  sticky: display demanded a pixel from an empty FIFO.
REQ-015 overflow_err  out  1  sticky: data returned while the FIFO was full.

Function
REQ-016 Request accepted only on a cycle with rd_req_valid and rd_req_ready both 1; rd_addr and rd_req_valid SHALL hold until accepted.
REQ-017 Credit rule: rd_req_valid SHALL be 1 only when FIFO occupancy + outstanding requests < FIFO_DEPTH and state is FETCH.
REQ-018 rd_addr SHALL start at 0, increment by 1 per accepted request, and wrap from H_PIXELS*V_PIXELS-1 to 0.
REQ-019 Outstanding count SHALL increment on request accept, decrement on rd_data_valid, and stay unchanged when both occur in the same cycle.
REQ-020 In FETCH, rd_data_valid SHALL push rd_data into the FIFO; a push when full SHALL be dropped and set overflow_err.
REQ-021 Pop SHALL occur on each cycle with disp_ena=1 and FIFO non-empty; the popped word SHALL appear on red/green/blue the next cycle.
REQ-022 With disp_ena=0, red/green/blue SHALL be 0 the next cycle and the FIFO SHALL not pop.
REQ-023 With disp_ena=1 and the FIFO empty, outputs SHALL be 0 next cycle, underflow SHALL set, and the internal frame_bad flag SHALL set.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; a pop of an empty FIFO and a same-cycle push SHALL NOT bypass (the pop counts as underflow).
REQ-025 Frame end SHALL be the cycle with disp_ena=1, column=H_PIXELS-1, row=V_PIXELS-1.
REQ-026 States: FETCH, FLUSH. FETCH->FLUSH at frame end when frame_bad=1 or underflow occurs on that same cycle; else stay FETCH and clear frame_bad.
REQ-027 In FLUSH: no requests; returning data discarded; FIFO cleared; when outstanding=0, rd_addr<=0, frame_bad<=0, go FETCH.
REQ-028 Display pops in FLUSH SHALL behave as underflow (outputs 0, underflow set).
REQ-029 Latency from disp_ena/syncs in to disp_ena_out/syncs out and pixel out SHALL be exactly 1 cycle.

Reset
REQ-030 On reset: state FETCH, rd_addr=0, rd_req_valid=0, outstanding=0, FIFO empty, frame_bad=0, underflow=0, overflow_err=0, red/green/blue=0, disp_ena_out=0, h_sync_out=0, v_sync_out=0.
REQ-031 Reset mid-transfer SHALL discard in-flight data; any rd_data_valid in the first cycle after reset SHALL be ignored and not counted.
REQ-032 Sticky flags SHALL clear only on reset.

Verification
REQ-033 Ready memory, 1-cycle latency, data=address -> after reset, requests 0..15 issue back-to-back; no more until pops begin.
REQ-034 Full 1920x1200 frame, zero-wait memory -> pixel (c,r) outputs data c+1920*r one cycle after its disp_ena; underflow=0.
REQ-035 rd_req_ready held 0 for 40 cycles during display -> underflow=1, outputs 0 while empty; after frame end FLUSH, next frame first pixel = address 0.
REQ-036 Force rd_data_valid with FIFO full -> overflow_err=1, FIFO contents unchanged.
REQ-037 Simultaneous accept and return with 4 outstanding -> outstanding stays 4; rd_addr wraps 2303999->0 at frame boundary.
REQ-038 Assert reset with 8 outstanding -> all outputs at reset values next cycle; late returns do not enter the FIFO.

Source files
------------

// File: rtl/vga_frame_reader_if.sv
// Read-request / read-data bus between the VGA frame reader (master) and frame memory (slave).
interface vga_frame_reader_if #(
  parameter int ADDR_W = 22
) ();
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_valid;
  logic [23:0]       rd_data;

  modport master (
    output rd_req_valid,
    output rd_addr,
    input  rd_req_ready,
    input  rd_data_valid,
    input  rd_data
  );

  modport slave (
    input  rd_req_valid,
    input  rd_addr,
    output rd_req_ready,
    output rd_data_valid,
    output rd_data
  );
endinterface

// File: rtl/vga_frame_reader.sv
// Prefetches frame-memory pixels into a small FIFO under a credit limit and feeds them to the
// display one cycle after each display-enable; a frame that underflows is flushed and restarted at 0.
module vga_frame_reader #(
  parameter int H_PIXELS   = 1920,
  parameter int V_PIXELS   = 1200,
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               disp_ena,
  input  logic [11:0]        column,
  input  logic [11:0]        row,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  vga_frame_reader_if.master mem,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic               disp_ena_out,
  output logic               underflow,
  output logic               overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);
  localparam logic [11:0]       LAST_COL  = 12'(H_PIXELS - 1);
  localparam logic [11:0]       LAST_ROW  = 12'(V_PIXELS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              req_valid_q, req_valid_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [23:0]       fifo_mem_q [FIFO_DEPTH];
  logic              frame_bad_q, frame_bad_d;
  logic              underflow_q, underflow_d;
  logic              overflow_q, overflow_d;
  logic              ignore_q;
  logic [23:0]       pixel_q, pixel_d;
  logic              de_q, hs_q, vs_q;

  logic fifo_empty_s, fifo_full_s, accept_s, rsp_s;
  logic push_s, pop_s, uf_evt_s, frame_end_s;

  // Handshake and FIFO event decode; a response in the first cycle after reset is ignored.
  always_comb begin
    fifo_empty_s = (count_q == '0);
    fifo_full_s  = (count_q == DEPTH_C);
    accept_s     = req_valid_q & mem.rd_req_ready;
    rsp_s        = mem.rd_data_valid & ~ignore_q;
    frame_end_s  = disp_ena & (column == LAST_COL) & (row == LAST_ROW);
    push_s       = (state_q == FETCH) & rsp_s & ~fifo_full_s;
    pop_s        = (state_q == FETCH) & disp_ena & ~fifo_empty_s;
    uf_evt_s     = disp_ena & ((state_q == FLUSH) | fifo_empty_s);
  end

  // Next-state logic for the fetch/flush machine, counters, pointers and pixel output.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    outst_d     = outst_q;
    wr_ptr_d    = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    frame_bad_d = frame_bad_q | uf_evt_s;
    underflow_d = underflow_q | uf_evt_s;
    overflow_d  = overflow_q | ((state_q == FETCH) & rsp_s & fifo_full_s);
    pixel_d     = pop_s ? fifo_mem_q[rd_ptr_q] : 24'h000000;

    if (accept_s) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
    end else begin
      rd_addr_d = rd_addr_q;
    end

    // A return with nothing outstanding cannot drive the count below zero.
    if (accept_s && !rsp_s) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!accept_s && rsp_s && (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end else begin
      outst_d = outst_q;
    end

    case (state_q)
      FETCH: begin
        if (frame_end_s) begin
          if (frame_bad_d) begin
            state_d = FLUSH;
          end else begin
            frame_bad_d = 1'b0;
          end
        end else begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        if (outst_q == '0) begin
          rd_addr_d   = '0;
          frame_bad_d = 1'b0;
          state_d     = FETCH;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    req_valid_d = (state_d == FETCH) &&
                  (({1'b0, count_d} + {1'b0, outst_d}) < {1'b0, DEPTH_C});
  end

  // State, counters, sticky flags and the one-cycle display pipeline.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= FETCH;
      rd_addr_q   <= '0;
      req_valid_q <= 1'b0;
      outst_q     <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_bad_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      ignore_q    <= 1'b1;
      pixel_q     <= 24'h000000;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      req_valid_q <= req_valid_d;
      outst_q     <= outst_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_bad_q <= frame_bad_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      ignore_q    <= 1'b0;
      pixel_q     <= pixel_d;
      de_q        <= disp_ena;
      hs_q        <= h_sync_in;
      vs_q        <= v_sync_in;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge pixel_clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= mem.rd_data;
    end
  end

  assign mem.rd_req_valid = req_valid_q;
  assign mem.rd_addr      = rd_addr_q;
  assign red              = pixel_q[23:16];
  assign green            = pixel_q[15:8];
  assign blue             = pixel_q[7:0];
  assign disp_ena_out     = de_q;
  assign h_sync_out       = hs_q;
  assign v_sync_out       = vs_q;
  assign underflow        = underflow_q;
  assign overflow_err     = overflow_q;

endmodule
